// File: rtl/bram_fifo_pkg.sv
// Shared sizing for the 2048x2 block-RAM FIFO controller.
package bram_fifo_pkg;

    localparam int DEPTH = 2048;   // words held by the external RAM
    localparam int AW    = 11;     // RAM address width
    localparam int DW    = 2;      // data width
    localparam int CW    = 12;     // occupancy width, holds 0..DEPTH

    // Convert an integer level into an occupancy-width constant.
    function automatic logic [CW-1:0] to_count(input int n);
        return CW'(n);
    endfunction

endpackage

// File: rtl/bram_fifo_ptr.sv
// Wrapping AW-bit address pointer with enable and synchronous reset.
module bram_fifo_ptr
    import bram_fifo_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic [AW-1:0] ptr
);

    logic [AW-1:0] ptr_reg;

    // Advance on enable; the natural AW-bit overflow wraps DEPTH-1 back to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg <= '0;
        end else if (en) begin
            ptr_reg <= ptr_reg + AW'(1);
        end
    end

    assign ptr = ptr_reg;

endmodule

// File: rtl/bram_fifo_ctrl_s2.sv
// FIFO controller driving an external 2048x2 true dual-port block RAM:
// port A writes, port B reads with one cycle of latency.
module bram_fifo_ctrl_s2
    import bram_fifo_pkg::*;
#(
    parameter int ALMOST_FULL_OFFSET  = 16,
    parameter int ALMOST_EMPTY_OFFSET = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [DW-1:0] din,
    input  logic          rd_en,
    output logic [DW-1:0] dout,
    output logic          valid,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty,
    output logic          wr_err,
    output logic          rd_err,
    output logic [CW-1:0] count,
    // RAM port A (write)
    output logic          clka,
    output logic [AW-1:0] addra,
    output logic [DW-1:0] dia,
    output logic          ena,
    output logic          wea,
    output logic          rsta,
    // RAM port B (read)
    output logic          clkb,
    output logic [AW-1:0] addrb,
    output logic          enb,
    output logic          web,
    output logic          rstb,
    input  logic [DW-1:0] dob
);

    localparam logic [CW-1:0] DEPTH_C  = to_count(DEPTH);
    localparam logic [CW-1:0] AF_LEVEL = to_count(DEPTH - ALMOST_FULL_OFFSET);
    localparam logic [CW-1:0] AE_LEVEL = to_count(ALMOST_EMPTY_OFFSET);

    logic [CW-1:0] count_reg, count_next;
    logic          full_reg, empty_reg, almost_full_reg, almost_empty_reg;
    logic          valid_reg, wr_err_reg, rd_err_reg;
    logic          wr_acc, rd_acc;
    logic [AW-1:0] wptr, rptr;

    // Accepts are gated by the registered flags, so a read and a write can
    // never address the same word in one cycle; reset masks all requests.
    always_comb begin
        wr_acc     = wr_en & ~full_reg & ~rst;
        rd_acc     = rd_en & ~empty_reg & ~rst;
        count_next = count_reg;
        case ({wr_acc, rd_acc})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    bram_fifo_ptr u_wptr (
        .clk (clk),
        .rst (rst),
        .en  (wr_acc),
        .ptr (wptr)
    );

    bram_fifo_ptr u_rptr (
        .clk (clk),
        .rst (rst),
        .en  (rd_acc),
        .ptr (rptr)
    );

    // Occupancy, status flags, read qualifier and error pulses, all
    // derived from the next occupancy so they move together with count.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg        <= '0;
            full_reg         <= 1'b0;
            empty_reg        <= 1'b1;
            almost_full_reg  <= 1'b0;
            almost_empty_reg <= 1'b1;
            valid_reg        <= 1'b0;
            wr_err_reg       <= 1'b0;
            rd_err_reg       <= 1'b0;
        end else begin
            count_reg        <= count_next;
            full_reg         <= (count_next == DEPTH_C);
            empty_reg        <= (count_next == '0);
            almost_full_reg  <= (count_next >= AF_LEVEL);
            almost_empty_reg <= (count_next <= AE_LEVEL);
            valid_reg        <= rd_acc;
            wr_err_reg       <= wr_en & full_reg;
            rd_err_reg       <= rd_en & empty_reg;
        end
    end

    assign count        = count_reg;
    assign full         = full_reg;
    assign empty        = empty_reg;
    assign almost_full  = almost_full_reg;
    assign almost_empty = almost_empty_reg;
    assign valid        = valid_reg;
    assign wr_err       = wr_err_reg;
    assign rd_err       = rd_err_reg;
    assign dout         = dob;

    assign clka  = clk;
    assign addra = wptr;
    assign dia   = din;
    assign ena   = wr_acc;
    assign wea   = wr_acc;
    assign rsta  = rst;

    assign clkb  = clk;
    assign addrb = rptr;
    assign enb   = rd_acc;
    assign web   = 1'b0;
    assign rstb  = rst;

endmodule

// File: tb/tb_bram_fifo_ctrl_s2.sv
// Self-checking bench: the FIFO is modelled as a queue of words plus
// running write/read totals; the block RAM lives here at the parent level.
module tb_bram_fifo_ctrl_s2;

    localparam int DEPTH = 2048;
    localparam int AFO   = 16;
    localparam int AEO   = 16;

    logic        clk, rst, wr_en, rd_en;
    logic [1:0]  din, dout, dia, dob;
    logic        valid, full, empty, almost_full, almost_empty, wr_err, rd_err;
    logic [11:0] count;
    logic        clka, clkb, ena, wea, rsta, enb, web, rstb;
    logic [10:0] addra, addrb;

    bram_fifo_ctrl_s2 #(
        .ALMOST_FULL_OFFSET  (AFO),
        .ALMOST_EMPTY_OFFSET (AEO)
    ) dut (
        .clk (clk), .rst (rst), .wr_en (wr_en), .din (din), .rd_en (rd_en),
        .dout (dout), .valid (valid), .full (full), .empty (empty),
        .almost_full (almost_full), .almost_empty (almost_empty),
        .wr_err (wr_err), .rd_err (rd_err), .count (count),
        .clka (clka), .addra (addra), .dia (dia), .ena (ena), .wea (wea), .rsta (rsta),
        .clkb (clkb), .addrb (addrb), .enb (enb), .web (web), .rstb (rstb), .dob (dob)
    );

    // 2048x2 true dual-port RAM: port A writes, port B reads registered.
    logic [1:0] mem [DEPTH];
    always @(posedge clka) if (ena && wea) mem[addra] <= dia;
    always @(posedge clkb) begin
        if (rstb)     dob <= 2'b00;
        else if (enb) dob <= mem[addrb];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [1:0] q[$];
    int         wtot, rtot;
    logic       exp_valid, exp_wr_err, exp_rd_err, exp_ena, exp_enb;
    logic [1:0] exp_dout;
    logic       ena_seen, wea_seen, enb_seen;

    // A read and a write must never hit the same RAM word in one cycle.
    always @(posedge clk) begin
        if (!rst && ena && enb) begin
            assert (addra != addrb)
            else begin
                errors++;
                $display("FAIL same_addr addra=%0d addrb=%0d required different", addra, addrb);
            end
        end
    end

    function automatic logic [43:0] expect_vec();
        int n = q.size();
        return {12'(n), n == DEPTH, n == 0, n >= DEPTH - AFO, n <= AEO,
                exp_valid, exp_wr_err, exp_rd_err,
                11'(wtot % DEPTH), 11'(rtot % DEPTH), exp_ena, exp_ena, exp_enb};
    endfunction

    function automatic logic [43:0] obs_vec();
        return {count, full, empty, almost_full, almost_empty, valid, wr_err, rd_err,
                addra, addrb, ena_seen, wea_seen, enb_seen};
    endfunction

    // One clock of normal operation; model advanced with the FIFO rules.
    task automatic cycle(input logic w, input logic r, input logic [1:0] d);
        @(negedge clk);
        rst = 1'b0; wr_en = w; rd_en = r; din = d;
        exp_ena = w && (q.size() < DEPTH);
        exp_enb = r && (q.size() > 0);
        #1;
        ena_seen = ena; wea_seen = wea; enb_seen = enb;
        @(posedge clk); #1;
        exp_wr_err = w && !exp_ena;
        exp_rd_err = r && !exp_enb;
        exp_valid  = exp_enb;
        if (exp_enb) begin exp_dout = q.pop_front(); rtot++; end
        if (exp_ena) begin q.push_back(d); wtot++; end
    endtask

    // One clock with reset asserted; requests are ignored, contents dropped.
    task automatic reset_cycle(input logic w, input logic r);
        @(negedge clk);
        rst = 1'b1; wr_en = w; rd_en = r; din = 2'($urandom);
        exp_ena = 1'b0; exp_enb = 1'b0;
        #1;
        ena_seen = ena; wea_seen = wea; enb_seen = enb;
        @(posedge clk); #1;
        q.delete(); wtot = 0; rtot = 0;
        exp_valid = 1'b0; exp_wr_err = 1'b0; exp_rd_err = 1'b0; exp_dout = 2'b00;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            reset_cycle(1'($urandom), 1'($urandom));
            checks++;
            if (obs_vec() !== expect_vec()) begin
                errors++;
                $display("FAIL reset_state i=%0d got=%h exp=%h", i, obs_vec(), expect_vec());
            end
            checks++;
            if (dout !== 2'b00) begin
                errors++;
                $display("FAIL reset_dout got=%0d exp=0", dout);
            end
        end
    endtask

    task automatic test_basic();
        logic [1:0] pat [6] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0};
        for (int i = 0; i < 6; i++) begin
            cycle(i < 3, i >= 3, pat[i]);
            checks++;
            if (obs_vec() !== expect_vec()) begin
                errors++;
                $display("FAIL basic_status i=%0d got=%h exp=%h", i, obs_vec(), expect_vec());
            end
            if (exp_valid) begin
                checks++;
                if (dout !== exp_dout) begin
                    errors++;
                    $display("FAIL basic_dout i=%0d got=%0d exp=%0d", i, dout, exp_dout);
                end
            end
        end
    endtask

    // Fill to full, try one extra write, then simultaneous write+read at full.
    task automatic test_fill_full();
        for (int i = 0; i < DEPTH + 2; i++) begin
            cycle(1'b1, i == DEPTH + 1, 2'($urandom));
            checks++;
            if (obs_vec() !== expect_vec()) begin
                errors++;
                $display("FAIL fill_status i=%0d got=%h exp=%h", i, obs_vec(), expect_vec());
            end
            if (exp_valid) begin
                checks++;
                if (dout !== exp_dout) begin
                    errors++;
                    $display("FAIL fill_dout i=%0d got=%0d exp=%0d", i, dout, exp_dout);
                end
            end
        end
    endtask

    // Drain to empty, then simultaneous write+read at empty, then drain.
    task automatic test_drain_empty();
        int n = q.size();
        for (int i = 0; i < n + 2; i++) begin
            cycle(i == n, 1'b1, 2'($urandom));
            checks++;
            if (obs_vec() !== expect_vec()) begin
                errors++;
                $display("FAIL drain_status i=%0d got=%h exp=%h", i, obs_vec(), expect_vec());
            end
            if (exp_valid) begin
                checks++;
                if (dout !== exp_dout) begin
                    errors++;
                    $display("FAIL drain_dout i=%0d got=%0d exp=%0d", i, dout, exp_dout);
                end
            end
        end
    endtask

    // Two full fill/drain rounds with data = address bits, pointers wrap to 0.
    task automatic test_wrap();
        reset_cycle(1'b0, 1'b0);
        for (int round = 0; round < 2; round++) begin
            for (int i = 0; i < 2 * DEPTH; i++) begin
                cycle(i < DEPTH, i >= DEPTH, 2'(wtot));
                checks++;
                if (obs_vec() !== expect_vec()) begin
                    errors++;
                    $display("FAIL wrap_status r=%0d i=%0d got=%h exp=%h", round, i, obs_vec(), expect_vec());
                end
                if (exp_valid) begin
                    checks++;
                    if (dout !== exp_dout) begin
                        errors++;
                        $display("FAIL wrap_dout r=%0d i=%0d got=%0d exp=%0d", round, i, dout, exp_dout);
                    end
                end
            end
        end
    endtask

    // Reset at occupancy 100 discards everything; a following read is rejected.
    task automatic test_midreset();
        for (int i = 0; i < 100; i++) cycle(1'b1, i > 95, 2'($urandom));
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 2'($urandom));
        checks++;
        if (count !== 12'd100) begin
            errors++;
            $display("FAIL midreset_pre count got=%0d exp=100", count);
        end
        reset_cycle(1'b1, 1'b1);
        checks++;
        if (obs_vec() !== expect_vec() || dout !== 2'b00) begin
            errors++;
            $display("FAIL midreset_state got=%h/%0d exp=%h/0", obs_vec(), dout, expect_vec());
        end
        cycle(1'b0, 1'b1, 2'b00);
        checks++;
        if (obs_vec() !== expect_vec()) begin
            errors++;
            $display("FAIL midreset_read got=%h exp=%h", obs_vec(), expect_vec());
        end
    endtask

    task automatic test_random();
        reset_cycle(1'b0, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            int wp = (i < 1500) ? 70 : 30;
            cycle($urandom_range(0, 99) < wp, $urandom_range(0, 99) < (100 - wp), 2'($urandom));
            checks++;
            if (obs_vec() !== expect_vec()) begin
                errors++;
                $display("FAIL random_status i=%0d got=%h exp=%h", i, obs_vec(), expect_vec());
            end
            if (exp_valid) begin
                checks++;
                if (dout !== exp_dout) begin
                    errors++;
                    $display("FAIL random_dout i=%0d got=%0d exp=%0d", i, dout, exp_dout);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = 2'b00;
        wtot = 0; rtot = 0;
        exp_valid = 1'b0; exp_wr_err = 1'b0; exp_rd_err = 1'b0;
        exp_ena = 1'b0; exp_enb = 1'b0; exp_dout = 2'b00;
        ena_seen = 1'b0; wea_seen = 1'b0; enb_seen = 1'b0;
        test_reset();
        test_basic();
        test_fill_full();
        test_drain_empty();
        test_wrap();
        test_midreset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
